// File: rtl/strided_mem_ctr_if.sv
// Core request/response and element-memory signal bundle for strided_mem_ctr.
// The slave modport is the controller's view; the master modport is the core plus memory side.
interface strided_mem_ctr_if #(
    parameter int ADDR_WIDTH       = 17,
    parameter int LEN              = 32,
    parameter int VECTOR_SIZE      = 8,
    parameter int ENTRY_INDEX_SIZE = 3
);
    logic                          req_valid;
    logic                          req_ready;
    logic                          is_vector;
    logic                          is_write;
    logic                          is_signed;
    logic [1:0]                    elem_width;
    logic [ADDR_WIDTH-1:0]         base_addr;
    logic [ADDR_WIDTH-1:0]         stride;
    logic [ENTRY_INDEX_SIZE:0]     vl;
    logic [VECTOR_SIZE-1:0]        mask;
    logic [LEN*VECTOR_SIZE-1:0]    wdata;
    logic [LEN*VECTOR_SIZE-1:0]    rdata;
    logic                          done;
    logic                          error;
    logic                          mem_req_valid;
    logic                          mem_we;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [1:0]                    mem_width;
    logic [LEN-1:0]                mem_wdata;
    logic                          mem_ack;
    logic [LEN-1:0]                mem_rdata;

    modport slave (
        input  req_valid, is_vector, is_write, is_signed, elem_width, base_addr, stride,
               vl, mask, wdata, mem_ack, mem_rdata,
        output req_ready, rdata, done, error, mem_req_valid, mem_we, mem_addr, mem_width,
               mem_wdata
    );

    modport master (
        output req_valid, is_vector, is_write, is_signed, elem_width, base_addr, stride,
               vl, mask, wdata, mem_ack, mem_rdata,
        input  req_ready, rdata, done, error, mem_req_valid, mem_we, mem_addr, mem_width,
               mem_wdata
    );
endinterface

// File: rtl/strided_mem_ctr.sv
// Strided vector load/store sequencer: walks up to VECTOR_SIZE elements at base + idx*stride,
// one memory request per active aligned element, aborting on the first misaligned one.
module strided_mem_ctr #(
    parameter int ADDR_WIDTH       = 17,
    parameter int LEN              = 32,
    parameter int VECTOR_SIZE      = 8,
    parameter int ENTRY_INDEX_SIZE = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    strided_mem_ctr_if.slave   bus
);
    localparam logic [ENTRY_INDEX_SIZE:0] MAX_LEN = (ENTRY_INDEX_SIZE+1)'(VECTOR_SIZE);
    localparam logic [ENTRY_INDEX_SIZE:0] ONE_IDX = (ENTRY_INDEX_SIZE+1)'(1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                      r_state;
    logic [ENTRY_INDEX_SIZE:0]   r_idx;
    logic [ENTRY_INDEX_SIZE:0]   r_len;
    logic [ADDR_WIDTH-1:0]       r_addr;
    logic [ADDR_WIDTH-1:0]       r_stride;
    logic [VECTOR_SIZE-1:0]      r_mask;
    logic [1:0]                  r_width;
    logic                        r_we;
    logic                        r_signed;
    logic                        r_error;
    logic [LEN*VECTOR_SIZE-1:0]  r_wdata;
    logic [LEN*VECTOR_SIZE-1:0]  r_rdata;

    logic [ENTRY_INDEX_SIZE-1:0] w_slot;
    logic                        w_in_range;
    logic                        w_misaligned;
    logic                        w_mem_req_valid;
    logic [ENTRY_INDEX_SIZE:0]   w_eff_len;

    function automatic logic [LEN-1:0] extend(input logic [LEN-1:0] d, input logic [1:0] w,
                                              input logic s);
        case (w)
            2'b00:   extend = {{(LEN-8){s & d[7]}}, d[7:0]};
            2'b01:   extend = {{(LEN-16){s & d[15]}}, d[15:0]};
            default: extend = d;  // word, and reserved 11 treated as word
        endcase
    endfunction

    assign w_slot          = r_idx[ENTRY_INDEX_SIZE-1:0];
    assign w_in_range      = (r_idx < r_len);
    assign w_misaligned    = (r_width == 2'b01 && r_addr[0]) ||
                             (r_width[1] && r_addr[1:0] != 2'b00);
    assign w_mem_req_valid = (r_state == ACCESS) && w_in_range && r_mask[w_slot] && !w_misaligned;
    assign w_eff_len       = !bus.is_vector       ? ONE_IDX :
                             (bus.vl > MAX_LEN)   ? MAX_LEN : bus.vl;

    // Request outputs decode the registered state so reset removes them without waiting for a clock.
    assign bus.req_ready     = (r_state == IDLE);
    assign bus.done          = (r_state == DONE);
    assign bus.error         = r_error;
    assign bus.rdata         = r_rdata;
    assign bus.mem_req_valid = w_mem_req_valid;
    assign bus.mem_we        = w_mem_req_valid & r_we;
    assign bus.mem_addr      = r_addr;
    assign bus.mem_width     = r_width;
    assign bus.mem_wdata     = r_wdata[w_slot*LEN +: LEN];

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_len    <= '0;
            r_addr   <= '0;
            r_stride <= '0;
            r_mask   <= '0;
            r_width  <= '0;
            r_we     <= 1'b0;
            r_signed <= 1'b0;
            r_error  <= 1'b0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_idx    <= '0;
                        r_len    <= w_eff_len;
                        r_addr   <= bus.base_addr;
                        r_stride <= bus.stride;
                        r_mask   <= bus.is_vector ? bus.mask : '1;
                        r_width  <= bus.elem_width;
                        r_we     <= bus.is_write;
                        r_signed <= bus.is_signed;
                        r_error  <= 1'b0;
                        r_wdata  <= bus.wdata;
                        r_rdata  <= '0;
                        r_state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!w_in_range) begin
                        r_state <= DONE;
                    end else if (!r_mask[w_slot]) begin
                        r_idx  <= r_idx + ONE_IDX;
                        r_addr <= r_addr + r_stride;
                    end else if (w_misaligned) begin
                        r_error <= 1'b1;
                        r_state <= DONE;
                    end else if (bus.mem_ack) begin
                        if (!r_we)
                            r_rdata[w_slot*LEN +: LEN] <= extend(bus.mem_rdata, r_width, r_signed);
                        r_idx  <= r_idx + ONE_IDX;
                        r_addr <= r_addr + r_stride;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
